// File: rtl/if_fetch_queue_if.sv
// Fetch-unit bundle: Execute redirect, Decode stall/head outputs, and the imem request/response channels.
// master = fetch queue, slave = surrounding pipeline plus instruction memory.
interface if_fetch_queue_if;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallD;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        InstrValidF;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;

  modport master (
    input  PCSrcE, PCTargetE, StallD, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output imem_req_valid, imem_req_addr, InstrValidF, InstrF, PCF, PCPlus4F
  );

  modport slave (
    output PCSrcE, PCTargetE, StallD, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  imem_req_valid, imem_req_addr, InstrValidF, InstrF, PCF, PCPlus4F
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Decoupled RV32I fetch: credit-limited imem requests fill a DEPTH-entry {pc,instr} FIFO; req N -> rsp N+1 -> InstrValidF N+2.
// StallD holds the head; requests stop once count+inflight+drop reaches DEPTH and resume the cycle after a pop.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  if_fetch_queue_if.master bus
);
  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] fetch_pc;
  logic [31:0] rsp_pc;
  logic [31:0] fifo_pc    [DEPTH];
  logic [31:0] fifo_instr [DEPTH];
  ptr_t        rd_ptr;
  ptr_t        wr_ptr;
  cnt_t        count;
  cnt_t        inflight;
  cnt_t        drop;

  logic [CW:0] credit_used;
  logic [31:0] target;
  logic        redirect;
  logic        req_vld;
  logic        req_fire;
  logic        rsp_take;
  logic        push;
  logic        head_vld;
  logic        pop;
  logic        unused_tgt_lsb;

  always_comb begin
    credit_used = {1'b0, count} + {1'b0, inflight} + {1'b0, drop};
    redirect    = bus.PCSrcE;
    target      = {bus.PCTargetE[31:2], 2'b00};
    req_vld     = reset_n && !redirect && (credit_used < DEPTH_C);
    req_fire    = req_vld && bus.imem_req_ready;
    // A response with nothing owed is a protocol error and is ignored.
    rsp_take    = bus.imem_rsp_valid && ((inflight != '0) || (drop != '0));
    push        = rsp_take && (drop == '0) && !redirect;
    head_vld    = (count != '0) && !redirect;
    pop         = head_vld && !bus.StallD;
  end

  assign unused_tgt_lsb     = ^bus.PCTargetE[1:0];
  assign bus.imem_req_valid = req_vld;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.InstrValidF    = head_vld;
  assign bus.InstrF         = fifo_instr[rd_ptr];
  assign bus.PCF            = fifo_pc[rd_ptr];
  assign bus.PCPlus4F       = fifo_pc[rd_ptr] + 32'd4;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect) begin
      // Everything still owed becomes stale, minus the response consumed this cycle.
      fetch_pc <= target;
      rsp_pc   <= target;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= drop + inflight - cnt_t'(rsp_take);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (rsp_take && (drop != '0)) drop <= drop - cnt_t'(1);
      if (push) begin
        rsp_pc <= rsp_pc + 32'd4;
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (pop) rd_ptr <= rd_ptr + ptr_t'(1);
      inflight <= inflight + cnt_t'(req_fire) - cnt_t'(push);
      count    <= count + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // Storage is reset so the head reads RESET_PC / 0 straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]    <= RESET_PC;
        fifo_instr[i] <= '0;
      end
    end else if (push) begin
      fifo_pc[wr_ptr]    <= rsp_pc;
      fifo_instr[wr_ptr] <= bus.imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed phases plus a randomized run against an in-order memory
// model and a program-order stream scoreboard.
module tb_if_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic clk;
  logic reset_n;
  if_fetch_queue_if bus();

  if_fetch_queue #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned rdy_pct = 100;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;

  logic [31:0] mq_addr [$];
  int unsigned mq_due  [$];
  logic [31:0] pop_log [$];

  logic [31:0] exp_pc, exp_req, hold_addr;
  bit          hold_pending;
  int          pops;

  bit          s_req_vld, s_fire, s_ivalid;
  logic [31:0] s_req_addr, s_pc, s_instr, s_pc4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq_addr.delete();
    mq_due.delete();
    exp_pc       = RPC;
    exp_req      = RPC;
    hold_pending = 1'b0;
  endtask

  // One clock cycle: entered and left at a negedge; inputs driven, outputs sampled 1ns later.
  task automatic step(input bit redir, input logic [31:0] tgt, input bit stall);
    logic [31:0] tgt_al;
    tgt_al = {tgt[31:2], 2'b00};
    bus.PCSrcE         = redir;
    bus.PCTargetE      = tgt;
    bus.StallD         = stall;
    bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
    if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    #1;
    s_req_vld  = bus.imem_req_valid;
    s_req_addr = bus.imem_req_addr;
    s_fire     = bus.imem_req_valid && bus.imem_req_ready;
    s_ivalid   = bus.InstrValidF;
    s_pc       = bus.PCF;
    s_instr    = bus.InstrF;
    s_pc4      = bus.PCPlus4F;
    if (redir) begin
      chk("ivalid_in_redirect", 32'(s_ivalid), 32'd0);
      chk("req_in_redirect", 32'(s_req_vld), 32'd0);
    end
    if (hold_pending && !redir) begin
      chk("req_hold_vld", 32'(s_req_vld), 32'd1);
      chk("req_hold_addr", s_req_addr, hold_addr);
    end
    if (s_req_vld) chk("req_addr", s_req_addr, exp_req);
    if (s_fire) begin
      mq_addr.push_back(s_req_addr);
      mq_due.push_back(cyc + $urandom_range(lat_max, lat_min));
      exp_req = exp_req + 32'd4;
    end
    hold_pending = s_req_vld && !s_fire;
    hold_addr    = s_req_addr;
    chk("outstanding_le_depth", 32'(mq_addr.size() <= DEPTH), 32'd1);
    if (s_ivalid && !stall) begin
      chk("pop_pc", s_pc, exp_pc);
      chk("pop_instr", s_instr, mem_word(exp_pc));
      chk("pop_pc4", s_pc4, exp_pc + 32'd4);
      pop_log.push_back(s_pc);
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (redir) begin
      exp_pc       = tgt_al;
      exp_req      = tgt_al;
      hold_pending = 1'b0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Redirect, stall 10 cycles: exactly DEPTH requests may issue; then release and drain in order.
  task automatic fill_check(input string tag, input logic [31:0] tgt);
    int f;
    rdy_pct = 100; lat_min = 1; lat_max = 1;
    step(1'b1, tgt, 1'b1);
    f = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'd0, 1'b1);
      f += int'(s_fire);
    end
    chk({tag, "_fires"}, f, DEPTH);
    chk({tag, "_req_low"}, 32'(s_req_vld), 32'd0);
    chk({tag, "_held_pc"}, s_pc, tgt);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 32'd0, 1'b0);
      chk({tag, "_drain_vld"}, 32'(s_ivalid), 32'd1);
      chk({tag, "_drain_pc"}, s_pc, tgt + 32'(4 * i));
      if (i == 0) chk({tag, "_req_at_release"}, 32'(s_req_vld), 32'd0);
      if (i == 1) chk({tag, "_req_after_pop"}, 32'(s_req_vld), 32'd1);
    end
  endtask

  initial begin
    int f;
    reset_n            = 1'b0;
    bus.PCSrcE         = 1'b0;
    bus.PCTargetE      = '0;
    bus.StallD         = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    pops = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_vld", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_ivalid", 32'(bus.InstrValidF), 32'd0);
    chk("rst_instr", bus.InstrF, 32'd0);
    chk("rst_pc", bus.PCF, RPC);
    chk("rst_pc4", bus.PCPlus4F, RPC + 32'd4);
    reset_n = 1'b1;

    // Stream with a 1-cycle memory: first request now, first instruction two cycles later.
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 32'd0, 1'b0);
      chk("stream_req_vld", 32'(s_req_vld), 32'd1);
      chk("stream_req_addr", s_req_addr, RPC + 32'(4 * k));
      chk("stream_ivalid", 32'(s_ivalid), 32'(k >= 2));
      if (k >= 2) chk("stream_pc", s_pc, RPC + 32'(4 * (k - 2)));
    end

    fill_check("backpressure", 32'h0000_0300);

    // Three requests outstanding, then redirect to an unaligned target.
    rdy_pct = 0;
    step(1'b1, 32'h0000_1000, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b0);
    rdy_pct = 100; lat_min = 6; lat_max = 6;
    f = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'd0, 1'b0);
      f += int'(s_fire);
    end
    chk("inflight_issued", f, 3);
    rdy_pct = 0;
    step(1'b1, 32'h0000_2003, 1'b0);
    rdy_pct = 100; lat_min = 1; lat_max = 1;
    pop_log.delete();
    step(1'b0, 32'd0, 1'b0);
    chk("redir_first_req_vld", 32'(s_req_vld), 32'd1);
    chk("redir_first_req_addr", s_req_addr, 32'h0000_2000);
    for (int i = 0; i < 13; i++) step(1'b0, 32'd0, 1'b0);
    chk("redir_pop_count_ok", 32'(pop_log.size() >= 4), 32'd1);
    if (pop_log.size() > 0) chk("redir_first_pop", pop_log[0], 32'h0000_2000);

    // Redirect while a response lands, then a second redirect on the next cycle.
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b0);
    step(1'b1, 32'h0000_0040, 1'b0);
    step(1'b1, 32'h0000_0080, 1'b0);
    pop_log.delete();
    for (int i = 0; i < 12; i++) step(1'b0, 32'd0, 1'b0);
    chk("dbl_pop_count_ok", 32'(pop_log.size() >= 4), 32'd1);
    if (pop_log.size() > 0) chk("dbl_first_pop", pop_log[0], 32'h0000_0080);
    fill_check("drop_cleared", 32'h0000_0500);

    // Randomized traffic: ready, latency, stall and redirects all vary.
    rdy_pct = 60; lat_min = 1; lat_max = 5;
    pops = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(99) < 3) step(1'b1, $urandom, 1'b0);
      else step(1'b0, 32'd0, ($urandom_range(99) < 30));
    end
    rdy_pct = 100;
    for (int i = 0; i < 20; i++) step(1'b0, 32'd0, 1'b0);
    chk("random_progress", 32'(pops > 300), 32'd1);
    fill_check("after_random", 32'h0000_0700);

    // Address wrap.
    lat_min = 1; lat_max = 1;
    step(1'b1, 32'hFFFF_FFFC, 1'b0);
    pop_log.delete();
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b0);
    chk("wrap_pop_count_ok", 32'(pop_log.size() >= 2), 32'd1);
    if (pop_log.size() >= 2) begin
      chk("wrap_pop0", pop_log[0], 32'hFFFF_FFFC);
      chk("wrap_pop1", pop_log[1], 32'h0000_0000);
    end

    // Asynchronous reset in the middle of a cycle, away from any clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_req_vld", 32'(bus.imem_req_valid), 32'd0);
    chk("arst_ivalid", 32'(bus.InstrValidF), 32'd0);
    chk("arst_instr", bus.InstrF, 32'd0);
    chk("arst_pc", bus.PCF, RPC);
    chk("arst_pc4", bus.PCPlus4F, RPC + 32'd4);
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    model_reset();
    reset_n = 1'b1;
    pop_log.delete();
    for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 1'b0);
    chk("post_rst_pop_count", pop_log.size(), 6);
    if (pop_log.size() > 0) chk("post_rst_first_pop", pop_log[0], RPC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
